// File: rtl/array_max_engine_pkg.sv
// ---------------------------------------------------------------------------
// array_max_engine_pkg
//   Shared definitions for the array maximum search engine:
//     - DEFAULT_WIDTH / DEFAULT_ADDR_WIDTH : default data and address widths
//     - state_t                            : engine FSM state encoding
// ---------------------------------------------------------------------------
package array_max_engine_pkg;

    localparam int DEFAULT_WIDTH      = 8;
    localparam int DEFAULT_ADDR_WIDTH = 8;

    // One state per cycle. WRITE_MAX / WRITE_IDX are only reachable when the
    // writeback feature is built in; the encoding is kept identical in both
    // builds so state values mean the same thing everywhere.
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_READ      = 3'd1,
        ST_WRITE_MAX = 3'd2,
        ST_WRITE_IDX = 3'd3,
        ST_DONE      = 3'd4
    } state_t;

endpackage : array_max_engine_pkg

// File: rtl/array_max_engine_max_compare_unit.sv
// ---------------------------------------------------------------------------
// max_compare_unit
//   Combinational running-maximum step: compares a candidate word against the
//   current maximum (unsigned) and selects the surviving value and index.
//   A strict greater-than is used so that, on ties, the earlier index wins.
//
// Ports
//   candidate        in   WIDTH       word just read from memory
//   candidate_index  in   ADDR_WIDTH  offset of that word from the base
//   current_max      in   WIDTH       maximum found so far
//   current_index    in   ADDR_WIDTH  offset of the maximum found so far
//   next_max         out  WIDTH       maximum after considering candidate
//   next_index       out  ADDR_WIDTH  offset belonging to next_max
// ---------------------------------------------------------------------------
module max_compare_unit #(
    parameter int WIDTH      = 8,
    parameter int ADDR_WIDTH = 8
) (
    input  logic [WIDTH-1:0]      candidate,
    input  logic [ADDR_WIDTH-1:0] candidate_index,
    input  logic [WIDTH-1:0]      current_max,
    input  logic [ADDR_WIDTH-1:0] current_index,
    output logic [WIDTH-1:0]      next_max,
    output logic [ADDR_WIDTH-1:0] next_index
);

    logic greater;

    // Both operands are declared unsigned, so this is an unsigned compare.
    assign greater    = candidate > current_max;
    assign next_max   = greater ? candidate       : current_max;
    assign next_index = greater ? candidate_index : current_index;

endmodule : max_compare_unit

// File: rtl/array_max_engine.sv
// ---------------------------------------------------------------------------
// array_max_engine
//   Scans `count` consecutive words of a data memory starting at
//   `baseAddress` (addresses wrap modulo 2^ADDR_WIDTH), tracks the largest
//   unsigned value and the offset of its first occurrence, optionally writes
//   both back to memory at dstAddress / dstAddress+1, then pulses `done`.
//
// Build option
//   ARRAY_MAX_WRITEBACK_EN  defined   : READ -> WRITE_MAX -> WRITE_IDX -> DONE
//                           undefined : READ -> DONE, memWrite/memWriteData
//                                       tied to 0, dstAddress ignored
//
// Ports
//   clock         in   1           sole clock, rising edge
//   reset         in   1           synchronous, active-high
//   start         in   1           request pulse, honoured only when idle
//   baseAddress   in   ADDR_WIDTH  first word address (captured on start)
//   count         in   ADDR_WIDTH  number of words to scan (captured on start)
//   dstAddress    in   ADDR_WIDTH  writeback address (captured on start)
//   memAddress    out  ADDR_WIDTH  data memory address
//   memWrite      out  1           memory write strobe (written next edge)
//   memWriteData  out  WIDTH       memory write data
//   memReadData   in   WIDTH       combinational read data for memAddress
//   busy          out  1           high whenever not idle
//   done          out  1           one-cycle completion pulse
//   maxValue      out  WIDTH       largest word found
//   maxIndex      out  ADDR_WIDTH  offset of first occurrence of maxValue
// ---------------------------------------------------------------------------
module array_max_engine
    import array_max_engine_pkg::*;
#(
    parameter int WIDTH      = DEFAULT_WIDTH,
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] baseAddress,
    input  logic [ADDR_WIDTH-1:0] count,
    input  logic [ADDR_WIDTH-1:0] dstAddress,
    output logic [ADDR_WIDTH-1:0] memAddress,
    output logic                  memWrite,
    output logic [WIDTH-1:0]      memWriteData,
    input  logic [WIDTH-1:0]      memReadData,
    output logic                  busy,
    output logic                  done,
    output logic [WIDTH-1:0]      maxValue,
    output logic [ADDR_WIDTH-1:0] maxIndex
);

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   base_q;
    logic [ADDR_WIDTH-1:0]   count_q;
    logic [ADDR_WIDTH-1:0]   offset_q;
    logic [WIDTH-1:0]        max_value_q;
    logic [ADDR_WIDTH-1:0]   max_index_q;

    logic [ADDR_WIDTH-1:0]   read_address;
    logic                    last_read;
    logic [WIDTH-1:0]        cmp_max;
    logic [ADDR_WIDTH-1:0]   cmp_index;

`ifdef ARRAY_MAX_WRITEBACK_EN
    logic [ADDR_WIDTH-1:0]   dst_q;
`else
    // Writeback is compiled out, so the destination is never looked at.
    logic                    unused_dst;
    assign unused_dst = ^dstAddress;
`endif

    // Natural ADDR_WIDTH-bit arithmetic gives the modulo-2^ADDR_WIDTH wrap.
    assign read_address = base_q + offset_q;

    // count_q is never 0 in READ (count==0 goes straight to DONE), so
    // count_q-1 is the offset of the final word.
    assign last_read = (offset_q == count_q - ADDR_WIDTH'(1));

    max_compare_unit #(
        .WIDTH      (WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_compare (
        .candidate       (memReadData),
        .candidate_index (offset_q),
        .current_max     (max_value_q),
        .current_index   (max_index_q),
        .next_max        (cmp_max),
        .next_index      (cmp_index)
    );

    // -----------------------------------------------------------------------
    // State and datapath registers
    // -----------------------------------------------------------------------
    // NOTE: every register here uses <= so all of them update from the same
    // pre-edge values; a blocking = would let later lines see new values.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            base_q      <= '0;
            count_q     <= '0;
            offset_q    <= '0;
            max_value_q <= '0;
            max_index_q <= '0;
`ifdef ARRAY_MAX_WRITEBACK_EN
            dst_q       <= '0;
`endif
        end else begin
            state_q <= state_d;
            case (state_q)
                ST_IDLE: begin
                    // Capture the job once; later changes on the inputs or
                    // further start pulses cannot disturb a running scan.
                    if (start) begin
                        base_q      <= baseAddress;
                        count_q     <= count;
                        offset_q    <= '0;
                        max_value_q <= '0;
                        max_index_q <= '0;
`ifdef ARRAY_MAX_WRITEBACK_EN
                        dst_q       <= dstAddress;
`endif
                    end
                end
                ST_READ: begin
                    offset_q    <= offset_q + ADDR_WIDTH'(1);
                    max_value_q <= cmp_max;
                    max_index_q <= cmp_index;
                end
                default: begin
                    // Result registers hold until the next accepted start.
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Next-state and memory-port decode
    // -----------------------------------------------------------------------
    // NOTE: every output of this block gets a default first, so no path
    // through the case can leave one unassigned and infer a latch.
    always_comb begin
        state_d      = state_q;
        memAddress   = '0;
        memWrite     = 1'b0;
        memWriteData = '0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = (count == '0) ? ST_DONE : ST_READ;
                end
            end

            ST_READ: begin
                memAddress = read_address;
                if (last_read) begin
`ifdef ARRAY_MAX_WRITEBACK_EN
                    state_d = ST_WRITE_MAX;
`else
                    state_d = ST_DONE;
`endif
                end
            end

`ifdef ARRAY_MAX_WRITEBACK_EN
            ST_WRITE_MAX: begin
                memWrite     = 1'b1;
                memAddress   = dst_q;
                memWriteData = max_value_q;
                state_d      = ST_WRITE_IDX;
            end

            ST_WRITE_IDX: begin
                memWrite     = 1'b1;
                memAddress   = dst_q + ADDR_WIDTH'(1);
                // Size cast zero-extends or truncates the index to a word.
                memWriteData = WIDTH'(max_index_q);
                state_d      = ST_DONE;
            end
`endif

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign busy     = (state_q != ST_IDLE);
    assign done     = (state_q == ST_DONE);
    assign maxValue = max_value_q;
    assign maxIndex = max_index_q;

endmodule : array_max_engine

// File: doc/array_max_engine.md
ARRAY_MAX_ENGINE -- requirements
Module: array_max_engine

Interface
REQ-001 Parameter: WIDTH, 8, data word width in bits (memory word and result value).
REQ-002 Parameter: ADDR_WIDTH, 8, memory address width in bits; also the width of count and index.
REQ-003 clock  input  1  sole clock; all state updates on posedge clock.
REQ-004 reset  input  1  synchronous, active-high reset, sampled on posedge clock.
REQ-005 start  input  1  request pulse; sampled only in IDLE.
REQ-006 baseAddress  input  ADDR_WIDTH  first array word address; captured on start.
REQ-007 count  input  ADDR_WIDTH  number of words to scan (0..255); captured on start.
REQ-008 dstAddress  input  ADDR_WIDTH  result writeback address; captured on start.
REQ-009 memAddress  output  ADDR_WIDTH  address to data memory.
REQ-010 memWrite  output  1  write strobe to data memory; the memory writes on the next posedge.
REQ-011 memWriteData  output  WIDTH  write data to data memory.
REQ-012 memReadData  input  WIDTH  combinational read data for the current memAddress (same cycle).
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 done  output  1  one-cycle completion pulse.
REQ-015 maxValue  output  WIDTH  largest word found, unsigned.
REQ-016 maxIndex  output  ADDR_WIDTH  offset from base of the first occurrence of maxValue.

Function
REQ-017 States: IDLE, READ, WRITE_MAX, WRITE_IDX, DONE; encoding is registered, one state per cycle.
REQ-018 IDLE: start=1 with count>0 captures the inputs, clears maxValue/maxIndex/offset to 0, and moves to READ; start=1 with count=0 moves to DONE with no memory access; start=0 stays in IDLE.
REQ-019 READ: memAddress = base+offset mod 2^ADDR_WIDTH; memReadData is sampled in the same cycle; offset increments each cycle; after offset count-1 the FSM moves to WRITE_MAX.
REQ-020 Comparison is unsigned; update only if memReadData > maxValue (strict), so the first occurrence of the maximum is kept; an all-zero array yields maxValue=0, maxIndex=0.
REQ-021 WRITE_MAX: memWrite=1, memAddress=dst, memWriteData=maxValue; then WRITE_IDX.
REQ-022 WRITE_IDX: memWrite=1, memAddress=dst+1 mod 2^ADDR_WIDTH, memWriteData=maxIndex zero-extended/truncated to WIDTH; then DONE.
REQ-023 DONE: done=1 for exactly one cycle; next state IDLE; maxValue/maxIndex hold until the next accepted start.
REQ-024 Latency (writeback build): start sampled at edge k gives READ cycles k+1..k+count, WRITE_MAX k+count+1, WRITE_IDX k+count+2, done high in cycle k+count+3.
REQ-025 start while busy is ignored; captured inputs do not change mid-operation.
REQ-026 memWrite=0 in all states other than WRITE_MAX/WRITE_IDX; memAddress=0 and memWriteData=0 in IDLE and DONE.

Reset
REQ-027 reset=1 forces IDLE on the next posedge: busy, done, memWrite, memAddress, memWriteData, maxValue, maxIndex and offset all go to 0.
REQ-028 reset mid-operation aborts immediately; no further memory write is issued, and there is no done pulse for the aborted job.

Configuration
REQ-029 Macro ARRAY_MAX_WRITEBACK_EN defined: the FSM includes WRITE_MAX/WRITE_IDX as in REQ-021..024.
REQ-030 Macro ARRAY_MAX_WRITEBACK_EN undefined: READ goes directly to DONE; memWrite is constant 0; memWriteData is constant 0; dstAddress is unused; done is high in cycle k+count+1.

Structure
REQ-031 The shared package holds the state enum type and the WIDTH/ADDR_WIDTH default constants.
REQ-032 One sub-module, max_compare_unit (combinational unsigned greater-than plus select of new max/index), is instantiated once; the FSM and registers stay in array_max_engine.

Verification
REQ-033 Memory preloaded mem[100..121]={10,7,75,9,3,4,5,6,7,8,9,90,10,12,13,14,15,120,1,2,3,4}; base=100, count=22, dst=200 -> maxValue=120, maxIndex=17, mem[200]=120, mem[201]=17, done at k+25.
REQ-034 Same preload, base=100, count=13 -> maxValue=90, maxIndex=11; no write touches mem[100..121].
REQ-035 Tie: mem[0]=5, mem[1]=5, base=0, count=2 -> maxIndex=0; wrap: mem[255]=3, mem[0]=9, base=255, count=2, dst=255 -> addresses 255,0 read; maxValue=9, maxIndex=1; writes go to 255 then 0.
REQ-036 count=0 -> no memWrite, maxValue=0, maxIndex=0, done at k+1; start pulsed during READ is ignored.
REQ-037 reset asserted in the cycle after the 5th READ -> next cycle IDLE, all outputs 0, no write to dst, no done pulse; a new start afterwards completes normally.
REQ-038 Both macro settings are run; without ARRAY_MAX_WRITEBACK_EN, REQ-033 gives the same results, memWrite never goes high, and done comes at k+23.
